// File: rtl/arrow_spawner.sv
// rtl/arrow_spawner.sv - arrow launch scheduler with score, lives and game-over tracking
// Optional ARROW_SPAWNER_INVERSE_EN enables the LFSR-driven parabolic reversal flag.
module arrow_spawner #(
    parameter int          NUM_LIVES = 3,
    parameter int          SPAWN_GAP = 30,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        start_in,
    input  logic        is_hit_in,
    input  logic        hit_player_in,
    output logic        valid_out,
    output logic [1:0]  direction_out,
    output logic        inversed_out,
    output logic [2:0]  speed_out,
    output logic        next_out,
    output logic [7:0]  score_out,
    output logic [1:0]  lives_out,
    output logic        game_over_out
);

    typedef enum logic [1:0] {IDLE, GAP, FLY, OVER} state_t;

    localparam logic [7:0] GAP_INIT   = 8'(SPAWN_GAP);
    localparam logic [1:0] LIVES_INIT = 2'(NUM_LIVES);
    localparam logic [7:0] FLY_LAST   = 8'd254;

    state_t      state;
    logic [7:0]  gap_cnt;
    logic [7:0]  fly_cnt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic        tick;
    logic        launch_inv;

    assign tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // Galois form, taps 16,14,13,11 folded into the 16'hB400 mask.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);

`ifdef ARROW_SPAWNER_INVERSE_EN
    assign launch_inv = lfsr[2];
`else
    assign launch_inv = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gap_cnt       <= 8'd0;
            fly_cnt       <= 8'd0;
            lfsr          <= LFSR_SEED;
            valid_out     <= 1'b0;
            direction_out <= 2'd0;
            inversed_out  <= 1'b0;
            speed_out     <= 3'd0;
            next_out      <= 1'b0;
            score_out     <= 8'd0;
            lives_out     <= 2'd0;
            game_over_out <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                IDLE, OVER: begin
                    if (start_in) begin
                        state         <= GAP;
                        score_out     <= 8'd0;
                        lives_out     <= LIVES_INIT;
                        gap_cnt       <= GAP_INIT;
                        game_over_out <= 1'b0;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == 8'd1) begin
                            state         <= FLY;
                            valid_out     <= 1'b1;
                            direction_out <= lfsr[1:0];
                            inversed_out  <= launch_inv;
                            speed_out     <= score_out[7:5];
                            next_out      <= ~next_out;
                            fly_cnt       <= 8'd0;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                end
                FLY: begin
                    // A resolution in the same cycle as a tick wins over the timeout count.
                    if (is_hit_in) begin
                        valid_out <= 1'b0;
                        gap_cnt   <= GAP_INIT;
                        if (!hit_player_in) begin
                            if (score_out != 8'hFF) score_out <= score_out + 8'd1;
                            state <= GAP;
                        end else begin
                            lives_out <= lives_out - 2'd1;
                            if (lives_out == 2'd1) begin
                                state         <= OVER;
                                game_over_out <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end else if (tick) begin
                        if (fly_cnt == FLY_LAST) begin
                            valid_out <= 1'b0;
                            gap_cnt   <= GAP_INIT;
                            state     <= GAP;
                        end else begin
                            fly_cnt <= fly_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arrow_spawner.sv
// tb/tb_arrow_spawner.sv - scoreboard bench for arrow_spawner
module tb_arrow_spawner;

    localparam int          NL   = 3;
    localparam int          SG   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        rst;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        start_in;
    logic        is_hit_in;
    logic        hit_player_in;
    logic        valid_out;
    logic [1:0]  direction_out;
    logic        inversed_out;
    logic [2:0]  speed_out;
    logic        next_out;
    logic [7:0]  score_out;
    logic [1:0]  lives_out;
    logic        game_over_out;

    arrow_spawner #(.NUM_LIVES(NL), .SPAWN_GAP(SG), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .start_in(start_in), .is_hit_in(is_hit_in), .hit_player_in(hit_player_in),
        .valid_out(valid_out), .direction_out(direction_out), .inversed_out(inversed_out),
        .speed_out(speed_out), .next_out(next_out), .score_out(score_out),
        .lives_out(lives_out), .game_over_out(game_over_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] dir;
        logic       inv;
        logic [2:0] spd;
        logic       nxt;
    } launch_t;

    launch_t    exp_q[$];
    launch_t    mon_e;
    logic       prev_v = 1'b0;
    bit         seen_inv0 = 0;
    bit         seen_inv1 = 0;
    logic [15:0] m_lfsr;
    logic [7:0]  exp_score;
    logic [1:0]  exp_lives;
    logic        exp_next;

    // Reference LFSR: shift right, XOR taps 16,14,13,11 when the dropped bit is 1.
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1 && prev_v === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_launch: got launch expected none");
            end else begin
                mon_e = exp_q.pop_front();
                chk("launch_dir", 32'(direction_out), 32'(mon_e.dir));
                chk("launch_inv", 32'(inversed_out), 32'(mon_e.inv));
                chk("launch_speed", 32'(speed_out), 32'(mon_e.spd));
                chk("launch_next", 32'(next_out), 32'(mon_e.nxt));
                if (inversed_out) seen_inv1 = 1;
                else              seen_inv0 = 1;
            end
        end
        prev_v <= valid_out;
    end

    task automatic do_tick();
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        @(negedge clk);
        hcount_in = 11'd7;
        vcount_in = 10'd3;
    endtask

    task automatic launch();
        launch_t e;
        for (int i = 1; i <= SG; i++) begin
            chk("gap_valid_low", 32'(valid_out), 32'd0);
            if (i == SG) begin
                exp_next = ~exp_next;
                e.dir = m_lfsr[1:0];
`ifdef ARROW_SPAWNER_INVERSE_EN
                e.inv = m_lfsr[2];
`else
                e.inv = 1'b0;
`endif
                e.spd = exp_score[7:5];
                e.nxt = exp_next;
                exp_q.push_back(e);
            end
            do_tick();
            if (i < SG) @(negedge clk);
        end
        chk("launch_rise", 32'(valid_out), 32'd1);
    endtask

    task automatic hit(input bit player);
        is_hit_in = 1'b1;
        hit_player_in = player;
        @(negedge clk);
        is_hit_in = 1'b0;
        hit_player_in = 1'b0;
        if (!player) begin
            if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
        end else begin
            exp_lives = exp_lives - 2'd1;
        end
        chk("hit_valid_fall", 32'(valid_out), 32'd0);
        chk("hit_score", 32'(score_out), 32'(exp_score));
        chk("hit_lives", 32'(lives_out), 32'(exp_lives));
        chk("hit_game_over", 32'(game_over_out), 32'(exp_lives == 2'd0));
    endtask

    task automatic start();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        exp_score = 8'd0;
        exp_lives = 2'(NL);
        chk("start_score", 32'(score_out), 32'd0);
        chk("start_lives", 32'(lives_out), 32'(NL));
        chk("start_game_over", 32'(game_over_out), 32'd0);
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_valid"}, 32'(valid_out), 32'd0);
        chk({name, "_score"}, 32'(score_out), 32'(exp_score));
        chk({name, "_lives"}, 32'(lives_out), 32'(exp_lives));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_in = 1'b0; is_hit_in = 1'b0; hit_player_in = 1'b0;
        hcount_in = 11'd7; vcount_in = 10'd3;
        exp_score = 8'd0; exp_lives = 2'd0; exp_next = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_dir", 32'(direction_out), 32'd0);
        chk("rst_speed", 32'(speed_out), 32'd0);
        chk("rst_next", 32'(next_out), 32'd0);
        chk("rst_score", 32'(score_out), 32'd0);
        chk("rst_lives", 32'(lives_out), 32'd0);
        chk("rst_game_over", 32'(game_over_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        is_hit_in = 1'b1;
        @(negedge clk);
        is_hit_in = 1'b0;
        check_quiet("idle_hit");

        start();
        launch();

        hit_player_in = 1'b1;
        @(negedge clk);
        hit_player_in = 1'b0;
        chk("lone_player_valid", 32'(valid_out), 32'd1);
        chk("lone_player_lives", 32'(lives_out), 32'(NL));

        hit(1'b0);

        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        chk("gap_start_score", 32'(score_out), 32'd1);
        launch();

        hit(1'b1);
        launch();
        hit(1'b1);
        launch();
        hit(1'b1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            @(negedge clk);
            chk("over_valid", 32'(valid_out), 32'd0);
            chk("over_flag", 32'(game_over_out), 32'd1);
        end
        is_hit_in = 1'b1;
        @(negedge clk);
        is_hit_in = 1'b0;
        check_quiet("over_hit");
        start();

        launch();
        for (int i = 0; i < 254; i++) do_tick();
        chk("timeout_hold", 32'(valid_out), 32'd1);
        do_tick();
        check_quiet("timeout");
        is_hit_in = 1'b1;
        @(negedge clk);
        is_hit_in = 1'b0;
        check_quiet("gap_hit");

        launch();
        hcount_in = 11'd0; vcount_in = 10'd0; is_hit_in = 1'b1;
        @(negedge clk);
        hcount_in = 11'd7; vcount_in = 10'd3; is_hit_in = 1'b0;
        exp_score = exp_score + 8'd1;
        check_quiet("hit_tick_prio");

        while (exp_score != 8'hFF) begin
            launch();
            hit(1'b0);
        end
        launch();
        chk("sat_speed", 32'(speed_out), 32'd7);
        hit(1'b0);

        launch();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_score = 8'd0; exp_lives = 2'd0; exp_next = 1'b0;
        check_quiet("rst_fly");
        chk("rst_fly_next", 32'(next_out), 32'd0);
        is_hit_in = 1'b1;
        @(negedge clk);
        is_hit_in = 1'b0;
        check_quiet("rst_fly_hit");
        start();
        launch();
        hit(1'b0);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef ARROW_SPAWNER_INVERSE_EN
        chk("inv_both_seen", 32'(seen_inv0 && seen_inv1), 32'd1);
`else
        chk("inv_never_one", 32'(seen_inv1), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
